// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// Each access runs IDLE -> ISSUE (memory strobed for one cycle) -> DONE (ack and read data).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_rw,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_rw,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  r0_ack_q, r0_ack_d;
  logic                  r1_ack_q, r1_ack_d;
  logic                  grant_vld, grant;

  // In DONE only the non-owner may be granted, so a waiting requester cannot be starved.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (r0_req && r1_req) begin
          grant_vld = 1'b1;
          grant     = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner_q;
        end else if (r0_req) begin
          grant_vld = 1'b1;
          grant     = 1'b0;
        end else if (r1_req) begin
          grant_vld = 1'b1;
          grant     = 1'b1;
        end
      end
      DONE: begin
        grant_vld = owner_q ? r0_req : r1_req;
        grant     = ~owner_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = IDLE;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_rw_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    if (state_q == ISSUE) begin
      state_d  = DONE;
      r0_ack_d = ~owner_q;
      r1_ack_d = owner_q;
    end
    // Only the granted requester's fields are ever looked at.
    if (grant_vld) begin
      state_d      = ISSUE;
      owner_d      = grant;
      last_owner_d = grant;
      if (grant) begin
        mem_rw_d   = r1_rw;
        mem_addr_d = r1_addr;
        mem_data_d = r1_wdata;
      end else begin
        mem_rw_d   = r0_rw;
        mem_addr_d = r0_addr;
        mem_data_d = r0_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      r0_ack_q     <= r0_ack_d;
      r1_ack_q     <= r1_ack_d;
    end
  end

  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign r0_ack   = r0_ack_q;
  assign r1_ack   = r1_ack_q;
  assign r0_rdata = r0_ack_q ? mem_q : '0;
  assign r1_rdata = r1_ack_q ? mem_q : '0;
endmodule
